// File: rtl/alu_issue_station.sv
// ALU reservation station: collapsing queue of decoded ops, 2-phase
// bundled-data issue to the ALU and result-broadcast wakeup.
module alu_issue_station #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_dispValid,
   output logic        o_dispReady,
   input  logic [3:0]  i_dispControl_4,
   input  logic [3:0]  i_dispTag_4,
   input  logic [4:0]  i_dispAreg_5,
   input  logic        i_dispSrc1Rdy,
   input  logic        i_dispSrc2Rdy,
   input  logic [31:0] i_dispSrc1Val_32,
   input  logic [31:0] i_dispSrc2Val_32,
   input  logic [3:0]  i_dispSrc1Tag_4,
   input  logic [3:0]  i_dispSrc2Tag_4,
   output logic        o_driveToAlu,
   input  logic        i_freeFromAlu,
   output logic [3:0]  o_controlToAlu_4,
   output logic [3:0]  o_tagToAlu_4,
   output logic [31:0] o_oprand1ToAlu_32,
   output logic [31:0] o_oprand2ToAlu_32,
   output logic [4:0]  o_aregToAlu_5,
   input  logic        i_driveFromAlu,
   output logic        o_freeToAlu,
   input  logic [31:0] i_resultFromAlu_32,
   input  logic [3:0]  i_indexFromAlu_4,
   output logic [2:0]  o_count_3,
   output logic        o_busy
);
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic        rdy;
      logic [31:0] val;
      logic [3:0]  tag;
   } src_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] ctrl;
      logic [3:0] tag;
      logic [4:0] areg;
      src_t       src1;
      src_t       src2;
   } entry_t;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   entry_t                 ent_q [DEPTH];
   entry_t                 ent_d [DEPTH];
   entry_t                 new_ent;
   entry_t                 sel_ent;
   state_t                 state_q;
   logic [SYNC_STAGES-1:0] drive_sync;
   logic [SYNC_STAGES-1:0] free_sync;
   logic                   rs;
   logic                   fs;
   logic                   res_fire;
   logic                   accept;
   logic                   issue;
   logic [DEPTH-1:0]       eligible;
   logic [SW-1:0]          sel;
   logic [2:0]             wr_slot;

   assign rs          = drive_sync[SYNC_STAGES-1];
   assign fs          = free_sync[SYNC_STAGES-1];
   assign res_fire    = rs != o_freeToAlu;
   assign o_dispReady = o_count_3 < 3'(DEPTH);
   assign accept      = i_dispValid & o_dispReady;
   assign o_busy      = state_q == S_WAIT;
   assign issue       = (state_q == S_IDLE) & (|eligible);
   assign wr_slot     = o_count_3 - {2'b0, issue};
   assign sel_ent     = ent_q[sel];

   always_comb begin
      eligible = '0;
      for (int i = 0; i < DEPTH; i++)
         eligible[i] = ent_q[i].valid & ent_q[i].src1.rdy & ent_q[i].src2.rdy;
   end

   always_comb begin
      sel = '0;
      for (int i = DEPTH-1; i >= 0; i--)
         if (eligible[i]) sel = SW'(i);
   end

   always_comb begin
      new_ent           = '0;
      new_ent.valid     = 1'b1;
      new_ent.ctrl      = i_dispControl_4;
      new_ent.tag       = i_dispTag_4;
      new_ent.areg      = i_dispAreg_5;
      new_ent.src1.rdy  = i_dispSrc1Rdy;
      new_ent.src1.val  = i_dispSrc1Val_32;
      new_ent.src1.tag  = i_dispSrc1Tag_4;
      new_ent.src2.rdy  = i_dispSrc2Rdy;
      new_ent.src2.val  = i_dispSrc2Val_32;
      new_ent.src2.tag  = i_dispSrc2Tag_4;
   end

   // Collapse first, then write dispatch, then wake on post-shift slots.
   always_comb begin
      for (int i = 0; i < DEPTH-1; i++)
         ent_d[i] = (issue && i >= int'(sel)) ? ent_q[i+1] : ent_q[i];
      ent_d[DEPTH-1] = issue ? '0 : ent_q[DEPTH-1];
      for (int i = 0; i < DEPTH; i++)
         if (accept && wr_slot == 3'(i)) ent_d[i] = new_ent;
      for (int i = 0; i < DEPTH; i++) begin
         if (res_fire && ent_d[i].valid) begin
            if (!ent_d[i].src1.rdy && ent_d[i].src1.tag == i_indexFromAlu_4) begin
               ent_d[i].src1.rdy = 1'b1;
               ent_d[i].src1.val = i_resultFromAlu_32;
            end
            if (!ent_d[i].src2.rdy && ent_d[i].src2.tag == i_indexFromAlu_4) begin
               ent_d[i].src2.rdy = 1'b1;
               ent_d[i].src2.val = i_resultFromAlu_32;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         state_q           <= S_IDLE;
         drive_sync        <= '0;
         free_sync         <= '0;
         o_count_3         <= '0;
         o_freeToAlu       <= 1'b0;
         o_driveToAlu      <= 1'b0;
         o_controlToAlu_4  <= '0;
         o_tagToAlu_4      <= '0;
         o_oprand1ToAlu_32 <= '0;
         o_oprand2ToAlu_32 <= '0;
         o_aregToAlu_5     <= '0;
      end else begin
         drive_sync <= SYNC_STAGES'({drive_sync, i_driveFromAlu});
         free_sync  <= SYNC_STAGES'({free_sync, i_freeFromAlu});
         ent_q      <= ent_d;
         o_count_3  <= o_count_3 + {2'b0, accept} - {2'b0, issue};
         if (res_fire) o_freeToAlu <= rs;
         unique case (state_q)
            S_IDLE: begin
               if (issue) begin
                  o_controlToAlu_4  <= sel_ent.ctrl;
                  o_tagToAlu_4      <= sel_ent.tag;
                  o_aregToAlu_5     <= sel_ent.areg;
                  o_oprand1ToAlu_32 <= sel_ent.src1.val;
                  o_oprand2ToAlu_32 <= sel_ent.src2.val;
                  o_driveToAlu      <= ~o_driveToAlu;
                  state_q           <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (fs == o_driveToAlu) state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_issue_station.sv
// Directed bench for alu_issue_station: bench-side ALU phases and
// a scoreboard of expected issues popped on each drive toggle.
module tb_alu_issue_station;
   logic        clk;
   logic        rstn;
   logic        i_dispValid;
   logic        o_dispReady;
   logic [3:0]  i_dispControl_4;
   logic [3:0]  i_dispTag_4;
   logic [4:0]  i_dispAreg_5;
   logic        i_dispSrc1Rdy;
   logic        i_dispSrc2Rdy;
   logic [31:0] i_dispSrc1Val_32;
   logic [31:0] i_dispSrc2Val_32;
   logic [3:0]  i_dispSrc1Tag_4;
   logic [3:0]  i_dispSrc2Tag_4;
   logic        o_driveToAlu;
   logic        i_freeFromAlu;
   logic [3:0]  o_controlToAlu_4;
   logic [3:0]  o_tagToAlu_4;
   logic [31:0] o_oprand1ToAlu_32;
   logic [31:0] o_oprand2ToAlu_32;
   logic [4:0]  o_aregToAlu_5;
   logic        i_driveFromAlu;
   logic        o_freeToAlu;
   logic [31:0] i_resultFromAlu_32;
   logic [3:0]  i_indexFromAlu_4;
   logic [2:0]  o_count_3;
   logic        o_busy;

   typedef struct {
      logic [3:0]  ctrl;
      logic [3:0]  tag;
      logic [4:0]  areg;
      logic [31:0] op1;
      logic [31:0] op2;
   } issue_t;

   issue_t sb[$];
   int     pass_cnt = 0;
   int     total_cnt = 0;
   logic   drv_ph = 1'b0;
   logic   free_ph = 1'b0;
   logic   res_ph = 1'b0;

   alu_issue_station #(.DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .i_dispValid       (i_dispValid),
      .o_dispReady       (o_dispReady),
      .i_dispControl_4   (i_dispControl_4),
      .i_dispTag_4       (i_dispTag_4),
      .i_dispAreg_5      (i_dispAreg_5),
      .i_dispSrc1Rdy     (i_dispSrc1Rdy),
      .i_dispSrc2Rdy     (i_dispSrc2Rdy),
      .i_dispSrc1Val_32  (i_dispSrc1Val_32),
      .i_dispSrc2Val_32  (i_dispSrc2Val_32),
      .i_dispSrc1Tag_4   (i_dispSrc1Tag_4),
      .i_dispSrc2Tag_4   (i_dispSrc2Tag_4),
      .o_driveToAlu      (o_driveToAlu),
      .i_freeFromAlu     (i_freeFromAlu),
      .o_controlToAlu_4  (o_controlToAlu_4),
      .o_tagToAlu_4      (o_tagToAlu_4),
      .o_oprand1ToAlu_32 (o_oprand1ToAlu_32),
      .o_oprand2ToAlu_32 (o_oprand2ToAlu_32),
      .o_aregToAlu_5     (o_aregToAlu_5),
      .i_driveFromAlu    (i_driveFromAlu),
      .o_freeToAlu       (o_freeToAlu),
      .i_resultFromAlu_32(i_resultFromAlu_32),
      .i_indexFromAlu_4  (i_indexFromAlu_4),
      .o_count_3         (o_count_3),
      .o_busy            (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] obs,
                        input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
   endtask

   task automatic expect_op(input logic [3:0] ctrl, input logic [3:0] tag,
                            input logic [4:0] areg, input logic [31:0] op1,
                            input logic [31:0] op2);
      issue_t e;
      e.ctrl = ctrl;
      e.tag  = tag;
      e.areg = areg;
      e.op1  = op1;
      e.op2  = op2;
      sb.push_back(e);
   endtask

   task automatic dispatch(input logic [3:0] ctrl, input logic [3:0] tag,
                           input logic [4:0] areg,
                           input logic r1, input logic [31:0] v1,
                           input logic [3:0] t1,
                           input logic r2, input logic [31:0] v2,
                           input logic [3:0] t2);
      i_dispValid      = 1'b1;
      i_dispControl_4  = ctrl;
      i_dispTag_4      = tag;
      i_dispAreg_5     = areg;
      i_dispSrc1Rdy    = r1;
      i_dispSrc1Val_32 = v1;
      i_dispSrc1Tag_4  = t1;
      i_dispSrc2Rdy    = r2;
      i_dispSrc2Val_32 = v2;
      i_dispSrc2Tag_4  = t2;
      tick();
      i_dispValid = 1'b0;
   endtask

   task automatic wait_issue(input string nm, output int lat);
      issue_t e;
      lat = 0;
      while (o_driveToAlu === drv_ph && lat < 20) begin
         tick();
         lat++;
      end
      drv_ph = ~drv_ph;
      check({nm, " drive"}, 64'(o_driveToAlu), 64'(drv_ph));
      check({nm, " sb nonempty"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({nm, " ctrl"}, 64'(o_controlToAlu_4), 64'(e.ctrl));
         check({nm, " tag"}, 64'(o_tagToAlu_4), 64'(e.tag));
         check({nm, " areg"}, 64'(o_aregToAlu_5), 64'(e.areg));
         check({nm, " op1"}, 64'(o_oprand1ToAlu_32), 64'(e.op1));
         check({nm, " op2"}, 64'(o_oprand2ToAlu_32), 64'(e.op2));
      end
   endtask

   task automatic ack(input string nm, output int lat);
      free_ph = ~free_ph;
      i_freeFromAlu = free_ph;
      lat = 0;
      while (o_busy === 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check({nm, " busy released"}, 64'(o_busy), 64'd0);
   endtask

   task automatic send_result(input logic [3:0] idx, input logic [31:0] val,
                              output int lat);
      res_ph = ~res_ph;
      i_indexFromAlu_4   = idx;
      i_resultFromAlu_32 = val;
      i_driveFromAlu     = res_ph;
      lat = 0;
      while (o_freeToAlu !== res_ph && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      rstn = 1'b0;
      i_dispValid = 1'b0;
      i_dispControl_4 = '0;
      i_dispTag_4 = '0;
      i_dispAreg_5 = '0;
      i_dispSrc1Rdy = 1'b0;
      i_dispSrc2Rdy = 1'b0;
      i_dispSrc1Val_32 = '0;
      i_dispSrc2Val_32 = '0;
      i_dispSrc1Tag_4 = '0;
      i_dispSrc2Tag_4 = '0;
      i_freeFromAlu = 1'b0;
      i_driveFromAlu = 1'b0;
      i_resultFromAlu_32 = '0;
      i_indexFromAlu_4 = '0;
      #2;
      check("rst count", 64'(o_count_3), 64'd0);
      check("rst ready", 64'(o_dispReady), 64'd1);
      check("rst drive", 64'(o_driveToAlu), 64'd0);
      check("rst free", 64'(o_freeToAlu), 64'd0);
      check("rst busy", 64'(o_busy), 64'd0);
      check("rst op1", 64'(o_oprand1ToAlu_32), 64'd0);
      tick();
      tick();
      rstn = 1'b1;

      // ready ADD issues one edge after dispatch
      expect_op(4'hF, 4'd3, 5'd1, 32'd5, 32'd7);
      dispatch(4'hF, 4'd3, 5'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
      check("t1 count", 64'(o_count_3), 64'd1);
      wait_issue("t1", lat);
      check("t1 latency", 64'(lat), 64'd1);
      check("t1 busy", 64'(o_busy), 64'd1);
      check("t1 count post", 64'(o_count_3), 64'd0);
      ack("t1", lat);
      check("t1 free latency", 64'(lat), 64'd3);

      // SUB waits on tag 3, woken by result
      expect_op(4'h1, 4'd4, 5'd2, 32'd20, 32'h0000000C);
      dispatch(4'h1, 4'd4, 5'd2, 1'b1, 32'd20, 4'd0, 1'b0, 32'd0, 4'd3);
      tick();
      tick();
      check("t2 held", 64'(o_driveToAlu), 64'(drv_ph));
      check("t2 count", 64'(o_count_3), 64'd1);
      send_result(4'd3, 32'h0000000C, lat);
      check("t2 ack latency", 64'(lat), 64'd3);
      wait_issue("t2", lat);
      check("t2 latency", 64'(lat), 64'd1);
      ack("t2", lat);

      // fill the station, all waiting on tag 9
      for (int k = 0; k < 4; k++) begin
         expect_op(4'(k + 2), 4'(k + 5), 5'(k + 5), 32'h99, 32'(k * 16 + 80));
         dispatch(4'(k + 2), 4'(k + 5), 5'(k + 5), 1'b0, 32'd0, 4'd9,
                  1'b1, 32'(k * 16 + 80), 4'd0);
      end
      check("t3 count full", 64'(o_count_3), 64'd4);
      check("t3 ready low", 64'(o_dispReady), 64'd0);
      dispatch(4'hF, 4'd15, 5'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
      tick();
      check("t3 overflow ignored", 64'(o_count_3), 64'd4);
      check("t3 no issue", 64'(o_driveToAlu), 64'(drv_ph));
      send_result(4'd9, 32'h99, lat);
      check("t3 ack latency", 64'(lat), 64'd3);
      for (int k = 0; k < 4; k++) begin
         wait_issue("t3", lat);
         check("t3 latency", 64'(lat), 64'd1);
         ack("t3", lat);
         check("t3 tag stable", 64'(o_tagToAlu_4), 64'(k + 5));
      end
      check("t3 drained", 64'(o_count_3), 64'd0);

      // result and dependent dispatch on the same edge
      expect_op(4'hF, 4'd12, 5'd9, 32'hFFFFFFFF, 32'd1);
      res_ph = ~res_ph;
      i_indexFromAlu_4 = 4'd2;
      i_resultFromAlu_32 = 32'hFFFFFFFF;
      i_driveFromAlu = res_ph;
      tick();
      tick();
      dispatch(4'hF, 4'd12, 5'd9, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0);
      check("t4 ack", 64'(o_freeToAlu), 64'(res_ph));
      check("t4 count", 64'(o_count_3), 64'd1);
      wait_issue("t4", lat);
      check("t4 latency", 64'(lat), 64'd1);
      ack("t4", lat);

      // unmatched result is acknowledged, nothing wakes
      dispatch(4'h3, 4'd11, 5'd11, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0, 4'd12);
      send_result(4'hA, 32'h1234, lat);
      check("t5 ack latency", 64'(lat), 64'd3);
      tick();
      tick();
      check("t5 count", 64'(o_count_3), 64'd1);
      check("t5 no issue", 64'(o_driveToAlu), 64'(drv_ph));

      // slot 1 issues past a blocked slot 0, then reset during WAIT
      expect_op(4'h5, 4'd13, 5'd3, 32'h33, 32'h44);
      dispatch(4'h5, 4'd13, 5'd3, 1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0);
      wait_issue("t6", lat);
      dispatch(4'h6, 4'd14, 5'd4, 1'b0, 32'd0, 4'd12, 1'b1, 32'd5, 4'd0);
      check("t6 count", 64'(o_count_3), 64'd2);
      check("t6 busy", 64'(o_busy), 64'd1);
      rstn = 1'b0;
      i_freeFromAlu = 1'b0;
      i_driveFromAlu = 1'b0;
      drv_ph = 1'b0;
      free_ph = 1'b0;
      res_ph = 1'b0;
      #1;
      check("t6 rst count", 64'(o_count_3), 64'd0);
      check("t6 rst drive", 64'(o_driveToAlu), 64'd0);
      check("t6 rst busy", 64'(o_busy), 64'd0);
      check("t6 rst tag", 64'(o_tagToAlu_4), 64'd0);
      check("t6 rst ctrl", 64'(o_controlToAlu_4), 64'd0);
      check("t6 rst op2", 64'(o_oprand2ToAlu_32), 64'd0);
      check("t6 rst ready", 64'(o_dispReady), 64'd1);
      tick();
      tick();
      rstn = 1'b1;
      expect_op(4'hF, 4'd1, 5'd4, 32'd100, 32'd200);
      dispatch(4'hF, 4'd1, 5'd4, 1'b1, 32'd100, 4'd0, 1'b1, 32'd200, 4'd0);
      wait_issue("t7", lat);
      check("t7 latency", 64'(lat), 64'd1);
      ack("t7", lat);
      check("sb empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
